// File: rtl/ad9284_spi_master.sv
// ad9284_spi_master
//   SPI configuration master for the AD9284 ADC. Accepts one register
//   command at a time and runs a 24-bit frame {rw, 2'b00, addr[12:0], byte}
//   MSB first on a 3-wire style bus, with a separate pad output enable so
//   the ADC can drive SDIO during the data byte of a read.
//
// Parameters
//   CLK_DIV  SCLK half-period in sys_clk cycles (2..255)
//   GAP_CYC  minimum CSB-high time between frames in sys_clk cycles (1..255)
//
// Ports
//   sys_clk, sys_rst_n          clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_rw, cmd_addr, cmd_wdata command fields (1 = read)
//   rsp_valid, rsp_rdata        one-cycle completion pulse and read byte
//   busy                        frame in progress (SETUP..GAP)
//   spi_csb, spi_sclk, spi_sdo  registered SPI outputs
//   spi_sdi                     serial data from the ADC
//   spi_sdio_oe                 SDIO pad output enable
module ad9284_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_sdo,
  input  logic        spi_sdi,
  output logic        spi_sdio_oe
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t      state_q, state_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [4:0]  bit_q, bit_n;
  logic [23:0] tx_q, tx_n;
  logic [7:0]  rx_q, rx_n;
  logic        rw_q, rw_n;
  logic        csb_q, csb_n;
  logic        sclk_q, sclk_n;
  logic        oe_q, oe_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [7:0]  rdata_q, rdata_n;

  // SDO is the top of the shift register; zeros shift in behind the frame,
  // so the line returns to 0 after the last falling edge without extra logic.
  assign spi_sdo     = tx_q[23];
  assign spi_csb     = csb_q;
  assign spi_sclk    = sclk_q;
  assign spi_sdio_oe = oe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign busy        = (state_q != IDLE);
  assign cmd_ready   = (state_q == IDLE) && sys_rst_n;

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    bit_n       = bit_q;
    tx_n        = tx_q;
    rx_n        = rx_q;
    rw_n        = rw_q;
    csb_n       = csb_q;
    sclk_n      = sclk_q;
    oe_n        = oe_q;
    rsp_valid_n = 1'b0;
    rdata_n     = rdata_q;

    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (cmd_valid) begin
          state_n = SETUP;
          tx_n    = {cmd_rw, 2'b00, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};
          rw_n    = cmd_rw;
          bit_n   = '0;
          rx_n    = '0;
          csb_n   = 1'b0;
          sclk_n  = 1'b0;
          oe_n    = 1'b1;
        end
      end

      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_n = '0;
          if (!sclk_q) begin
            // Rising edge: the read byte occupies frame bits 7..0.
            sclk_n = 1'b1;
            if (bit_q >= 5'd16) begin
              rx_n = {rx_q[6:0], spi_sdi};
            end
          end else begin
            // Falling edge: advance to the next bit (or finish the frame).
            sclk_n = 1'b0;
            tx_n   = {tx_q[22:0], 1'b0};
            if (bit_q == 5'd23) begin
              state_n = HOLD;
              oe_n    = 1'b0;
            end else begin
              bit_n = bit_q + 5'd1;
              oe_n  = !(rw_q && (bit_q >= 5'd15));
            end
          end
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_n     = GAP;
          cnt_n       = '0;
          csb_n       = 1'b1;
          rsp_valid_n = 1'b1;
          rdata_n     = rw_q ? rx_q : 8'h00;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        csb_n   = 1'b1;
        sclk_n  = 1'b0;
        oe_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      csb_q       <= 1'b1;
      sclk_q      <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      bit_q       <= bit_n;
      tx_q        <= tx_n;
      rx_q        <= rx_n;
      rw_q        <= rw_n;
      csb_q       <= csb_n;
      sclk_q      <= sclk_n;
      oe_q        <= oe_n;
      rsp_valid_q <= rsp_valid_n;
      rdata_q     <= rdata_n;
    end
  end

endmodule

// File: tb/tb_ad9284_spi_master.sv
// Directed bench for ad9284_spi_master: one instance at default parameters
// and one at CLK_DIV=2. Inputs change at negedge or 1ns after posedge;
// outputs are sampled 1ns after posedge.
module tb_ad9284_spi_master;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [12:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy, spi_csb, spi_sclk, spi_sdo, spi_sdi, spi_sdio_oe;

  logic        cmd_valid_b, cmd_ready_b, cmd_rw_b;
  logic [12:0] cmd_addr_b;
  logic [7:0]  cmd_wdata_b;
  logic        rsp_valid_b;
  logic [7:0]  rsp_rdata_b;
  logic        busy_b, spi_csb_b, spi_sclk_b, spi_sdo_b, spi_sdi_b, spi_sdio_oe_b;

  int errors = 0;
  int checks = 0;

  ad9284_spi_master #(.CLK_DIV(4), .GAP_CYC(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_sdo(spi_sdo),
    .spi_sdi(spi_sdi), .spi_sdio_oe(spi_sdio_oe)
  );

  ad9284_spi_master #(.CLK_DIV(2), .GAP_CYC(4)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_rw(cmd_rw_b),
    .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
    .spi_csb(spi_csb_b), .spi_sclk(spi_sclk_b), .spi_sdo(spi_sdo_b),
    .spi_sdi(spi_sdi_b), .spi_sdio_oe(spi_sdio_oe_b)
  );

  // Issues one command on dut and follows it until cmd_ready returns.
  // The ADC model drives rd_model on SDI ahead of rising edges 17..24.
  // poke_at > 0 pulses an unrelated read command for one cycle mid-frame.
  task automatic run_frame(input logic rw, input logic [12:0] addr,
                           input logic [7:0] wd, input logic [7:0] rd_model,
                           input int poke_at,
                           output int len, output logic [23:0] fr,
                           output logic [23:0] oe, output int rises,
                           output int rsp, output logic [7:0] rd);
    logic prev;
    @(negedge sys_clk);
    cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1; spi_sdi = 1'b0;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0; cmd_addr = 13'h1FFF; cmd_wdata = 8'hEE; cmd_rw = ~rw;
    len = 0; fr = '0; oe = '0; rises = 0; rsp = 0; rd = 8'h00; prev = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge sys_clk); #1;
      len = n;
      if (spi_sclk && !prev) begin
        fr = {fr[22:0], spi_sdo};
        oe = {oe[22:0], spi_sdio_oe};
        rises++;
      end
      prev = spi_sclk;
      if (rsp_valid) begin
        rsp++;
        rd = rsp_rdata;
      end
      spi_sdi = (rises >= 16 && rises < 24) ? rd_model[23 - rises] : 1'b0;
      if (n == poke_at) begin
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 13'h1FFF; cmd_wdata = 8'hFF;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_ready) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({spi_csb, spi_sclk, spi_sdo, spi_sdio_oe} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_spi: got csb/sclk/sdo/oe=%b expected 1000",
               {spi_csb, spi_sclk, spi_sdo, spi_sdio_oe});
    end
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got rsp_valid/busy/ready=%b expected 000",
               {rsp_valid, busy, cmd_ready});
    end
    checks++;
    if (rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00", rsp_rdata);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int len, rises, rsp;
    logic [23:0] fr, oe;
    logic [7:0] rd;
    run_frame(1'b0, 13'h008, 8'h03, 8'h00, -1, len, fr, oe, rises, rsp, rd);
    checks++;
    if (fr !== 24'h000803) begin
      errors++; $display("FAIL write_frame: got %h expected 000803", fr);
    end
    checks++;
    if (oe !== 24'hFFFFFF) begin
      errors++; $display("FAIL write_oe: got %h expected ffffff", oe);
    end
    checks++;
    if (rises !== 24) begin
      errors++; $display("FAIL write_rises: got %0d expected 24", rises);
    end
    checks++;
    if (rsp !== 1 || rd !== 8'h00) begin
      errors++; $display("FAIL write_rsp: got count %0d rdata %h expected 1 00", rsp, rd);
    end
    checks++;
    if (len !== 204) begin
      errors++; $display("FAIL write_len: got %0d expected 204", len);
    end
  endtask

  task automatic test_read();
    int len, rises, rsp;
    logic [23:0] fr, oe;
    logic [7:0] rd;
    run_frame(1'b1, 13'h001, 8'h5C, 8'hA5, -1, len, fr, oe, rises, rsp, rd);
    checks++;
    if (fr !== 24'h800100) begin
      errors++; $display("FAIL read_frame: got %h expected 800100", fr);
    end
    checks++;
    if (oe !== 24'hFFFF00) begin
      errors++; $display("FAIL read_oe: got %h expected ffff00", oe);
    end
    checks++;
    if (rsp !== 1 || rd !== 8'hA5) begin
      errors++; $display("FAIL read_rsp: got count %0d rdata %h expected 1 a5", rsp, rd);
    end
    checks++;
    if (len !== 204) begin
      errors++; $display("FAIL read_len: got %0d expected 204", len);
    end
    repeat (10) @(posedge sys_clk);
    #1;
    checks++;
    if (rsp_rdata !== 8'hA5 || spi_sdio_oe !== 1'b0) begin
      errors++; $display("FAIL read_hold: got rdata %h oe %b expected a5 0", rsp_rdata, spi_sdio_oe);
    end
  endtask

  task automatic test_write_after_read();
    int len, rises, rsp;
    logic [23:0] fr, oe;
    logic [7:0] rd;
    run_frame(1'b0, 13'h1AB, 8'h66, 8'hFF, -1, len, fr, oe, rises, rsp, rd);
    checks++;
    if (fr !== 24'h01AB66) begin
      errors++; $display("FAIL war_frame: got %h expected 01ab66", fr);
    end
    checks++;
    if (rsp !== 1 || rd !== 8'h00) begin
      errors++; $display("FAIL war_rsp: got count %0d rdata %h expected 1 00", rsp, rd);
    end
  endtask

  task automatic test_back_to_back();
    int hi, gap, second_at, len, rsp, ready_bad, rises;
    logic prev;
    logic [23:0] fr1, fr2;
    hi = 0; gap = 0; second_at = 0; len = 0; rsp = 0; ready_bad = 0; rises = 0;
    prev = 1'b0; fr1 = '0; fr2 = '0;
    @(negedge sys_clk);
    cmd_rw = 1'b0; cmd_addr = 13'h123; cmd_wdata = 8'h5A; cmd_valid = 1'b1; spi_sdi = 1'b0;
    @(posedge sys_clk); #1;
    cmd_addr = 13'h0AA; cmd_wdata = 8'hC3;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge sys_clk); #1;
      if (n < 204 && cmd_ready) ready_bad++;
      if (spi_sclk && !prev) begin
        rises++;
        if (gap == 0) fr1 = {fr1[22:0], spi_sdo};
        else          fr2 = {fr2[22:0], spi_sdo};
      end
      prev = spi_sclk;
      if (rsp_valid) rsp++;
      if (spi_csb) begin
        hi++;
      end else if (hi > 0 && gap == 0) begin
        gap = hi;
        second_at = n;
        cmd_valid = 1'b0;
      end
      if (gap > 0 && cmd_ready) begin
        len = n;
        break;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (ready_bad !== 0) begin
      errors++; $display("FAIL b2b_ready_in_frame: got %0d high samples expected 0", ready_bad);
    end
    checks++;
    if (!(gap >= 4)) begin
      errors++; $display("FAIL b2b_csb_gap: got %0d cycles expected >=4", gap);
    end
    checks++;
    if (second_at !== 205) begin
      errors++; $display("FAIL b2b_second_start: got %0d expected 205", second_at);
    end
    checks++;
    if (fr1 !== 24'h01235A || fr2 !== 24'h00AAC3) begin
      errors++; $display("FAIL b2b_frames: got %h %h expected 01235a 00aac3", fr1, fr2);
    end
    checks++;
    if (len !== 409 || rsp !== 2) begin
      errors++; $display("FAIL b2b_len_rsp: got len %0d rsp %0d expected 409 2", len, rsp);
    end
  endtask

  task automatic test_valid_while_busy();
    int len, rises, rsp, lows;
    logic [23:0] fr, oe;
    logic [7:0] rd;
    run_frame(1'b0, 13'h055, 8'h99, 8'h00, 50, len, fr, oe, rises, rsp, rd);
    checks++;
    if (fr !== 24'h005599 || oe !== 24'hFFFFFF) begin
      errors++; $display("FAIL busy_frame: got %h oe %h expected 005599 ffffff", fr, oe);
    end
    checks++;
    if (len !== 204 || rsp !== 1) begin
      errors++; $display("FAIL busy_len_rsp: got len %0d rsp %0d expected 204 1", len, rsp);
    end
    lows = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge sys_clk); #1;
      if (!spi_csb || busy || rsp_valid) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++; $display("FAIL busy_no_second_frame: got %0d active cycles expected 0", lows);
    end
  endtask

  task automatic test_reset_midframe();
    int rises, rsp, len;
    logic prev;
    logic [23:0] fr, oe;
    logic [7:0] rd;
    rises = 0; rsp = 0; prev = 1'b0;
    @(negedge sys_clk);
    cmd_rw = 1'b0; cmd_addr = 13'h0F0; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge sys_clk); #1;
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
      if (rsp_valid) rsp++;
      if (rises == 12) break;
    end
    checks++;
    if (rises !== 12 || spi_sclk !== 1'b1) begin
      errors++; $display("FAIL rstmid_reach_bit12: got rises %0d sclk %b expected 12 1", rises, spi_sclk);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (spi_csb !== 1'b1 || spi_sclk !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got csb %b sclk %b expected 1 0", spi_csb, spi_sclk);
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b0 || spi_sdio_oe !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctl: got busy %b ready %b oe %b expected 0 0 0",
                         busy, cmd_ready, spi_sdio_oe);
    end
    repeat (3) begin
      @(posedge sys_clk); #1;
      if (rsp_valid) rsp++;
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready_after: got %b expected 1", cmd_ready);
    end
    for (int n = 0; n < 250; n++) begin
      @(posedge sys_clk); #1;
      if (rsp_valid) rsp++;
    end
    checks++;
    if (rsp !== 0) begin
      errors++; $display("FAIL rstmid_no_rsp: got %0d pulses expected 0", rsp);
    end
    run_frame(1'b0, 13'h010, 8'h77, 8'h00, -1, len, fr, oe, rises, rsp, rd);
    checks++;
    if (fr !== 24'h001077 || len !== 204 || rsp !== 1 || rd !== 8'h00) begin
      errors++; $display("FAIL rstmid_recover: got frame %h len %0d rsp %0d rdata %h expected 001077 204 1 00",
                         fr, len, rsp, rd);
    end
  endtask

  task automatic test_clkdiv2();
    int len, rises, rsp, r1, r2;
    logic prev;
    logic [23:0] fr;
    len = 0; rises = 0; rsp = 0; r1 = 0; r2 = 0; prev = 1'b0; fr = '0;
    @(negedge sys_clk);
    cmd_rw_b = 1'b0; cmd_addr_b = 13'h0FF; cmd_wdata_b = 8'h01; cmd_valid_b = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid_b = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge sys_clk); #1;
      len = n;
      if (spi_sclk_b && !prev) begin
        rises++;
        fr = {fr[22:0], spi_sdo_b};
        if (rises == 1) r1 = n;
        if (rises == 2) r2 = n;
      end
      prev = spi_sclk_b;
      if (rsp_valid_b) rsp++;
      if (cmd_ready_b) break;
    end
    checks++;
    if (r1 !== 4 || (r2 - r1) !== 4) begin
      errors++; $display("FAIL div2_sclk: got first rise %0d period %0d expected 4 4", r1, r2 - r1);
    end
    checks++;
    if (fr !== 24'h00FF01 || rises !== 24) begin
      errors++; $display("FAIL div2_frame: got %h rises %0d expected 00ff01 24", fr, rises);
    end
    checks++;
    if (len !== 104 || rsp !== 1) begin
      errors++; $display("FAIL div2_len_rsp: got len %0d rsp %0d expected 104 1", len, rsp);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0; spi_sdi = 1'b0;
    cmd_valid_b = 1'b0; cmd_rw_b = 1'b0; cmd_addr_b = '0; cmd_wdata_b = '0; spi_sdi_b = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_write_after_read();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_midframe();
    test_clkdiv2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9284_spi_master.md
AD9284_SPI_MASTER -- requirements
Module: ad9284_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; SCLK half-period in sys_clk cycles; legal range 2..255.
REQ-002 SHALL have parameter GAP_CYC, default 4; minimum CSB-high time between frames, in sys_clk cycles; legal range 1..255.
REQ-003 SHALL have port sys_clk, input, 1 bit; the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit; a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit; the block can accept a command.
REQ-007 SHALL have port cmd_rw, input, 1 bit; 1 = read, 0 = write.
REQ-008 SHALL have port cmd_addr, input, 13 bits; ADC register address.
REQ-009 SHALL have port cmd_wdata, input, 8 bits; write data; ignored for reads.
REQ-010 SHALL have port rsp_valid, output, 1 bit; one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 8 bits; read result.
REQ-012 SHALL have port busy, output, 1 bit; high while a frame is in progress.
REQ-013 SHALL have port spi_csb, output, 1 bit; active-low chip select.
REQ-014 SHALL have port spi_sclk, output, 1 bit; serial clock, idle low.
REQ-015 SHALL have port spi_sdo, output, 1 bit; serial data to the ADC.
REQ-016 SHALL have port spi_sdi, input, 1 bit; serial data from the ADC.
REQ-017 SHALL have port spi_sdio_oe, output, 1 bit; output enable for the SDIO pad.

Function
REQ-018 SHALL accept a command on any rising edge where cmd_valid && cmd_ready, latching cmd_rw, cmd_addr and cmd_wdata.
REQ-019 SHALL drive cmd_ready high only in state IDLE; cmd_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-020 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, with no other transitions.
REQ-021 SHALL transmit a 24-bit frame, MSB first, as {cmd_rw, 2'b00, cmd_addr[12:0], byte}; byte = cmd_wdata for writes and don't-care (driven 0) for reads.
REQ-022 SETUP: SHALL drive spi_csb low from the cycle after acceptance, present bit 23 on spi_sdo, hold spi_sclk low, and last CLK_DIV cycles.
REQ-023 SHIFT: each bit SHALL take 2*CLK_DIV cycles (sclk low CLK_DIV cycles, then high CLK_DIV cycles); spi_sdo SHALL change only while sclk falls or is low; 24 bits total.
REQ-024 SHALL sample spi_sdi on the sys_clk edge where spi_sclk rises, for read data bits 7..0 (frame bits 7..0), MSB first.
REQ-025 SHALL drive spi_sdio_oe high for frame bits 23..8 always, and for bits 7..0 on writes; it SHALL be low for bits 7..0 on reads and outside the SETUP/SHIFT states.
REQ-026 HOLD: SHALL keep spi_csb low and spi_sclk low for CLK_DIV cycles after the final high phase.
REQ-027 GAP: SHALL drive spi_csb high for GAP_CYC cycles; rsp_valid SHALL pulse for exactly 1 cycle on the first GAP cycle.
REQ-028 On a read, rsp_rdata SHALL update to the sampled byte in the same cycle as rsp_valid.
REQ-029 On a write, rsp_rdata SHALL be 8'h00 while rsp_valid is high.
REQ-030 rsp_rdata SHALL hold its value between pulses.
REQ-031 busy SHALL be high in SETUP, SHIFT, HOLD and GAP.
REQ-032 Frame length from the acceptance edge to the re-entry of IDLE SHALL be CLK_DIV*50 + GAP_CYC cycles (204 with defaults).
REQ-033 The SPI outputs (spi_csb, spi_sclk, spi_sdo, spi_sdio_oe) SHALL be registered, with no combinational path from the cmd_* inputs.

Reset
REQ-034 SHALL, on sys_rst_n low (asynchronously, including mid-frame), force state IDLE, spi_csb=1, spi_sclk=0, spi_sdo=0, spi_sdio_oe=0, rsp_valid=0, rsp_rdata=8'h00, busy=0 and bit/divider counters to 0.
REQ-035 cmd_ready SHALL be 0 while sys_rst_n is low and 1 on the first cycle after release.
REQ-036 An aborted frame SHALL produce no rsp_valid.

Verification
REQ-037 SHALL cover a write: addr 0x008, data 0x03 -> spi_sdo bits 0x000803 over 24 rising sclk edges, oe high throughout, rsp_valid once with rdata 0x00, IDLE after 204 cycles.
REQ-038 SHALL cover a read: addr 0x001, ADC model returns 0xA5 -> instruction 0x8001, oe low for the last 8 bits, rsp_rdata=0xA5 with rsp_valid.
REQ-039 SHALL cover back-to-back commands: cmd_valid held high for two commands -> second accepted only after GAP, csb high >=4 cycles between frames, cmd_ready low throughout frame 1.
REQ-040 SHALL cover cmd_valid while busy: pulse cmd_valid at frame cycle 50 -> no second frame, no effect on frame 1 bits.
REQ-041 SHALL cover reset mid-frame: assert sys_rst_n low at bit 12 -> csb=1 and sclk=0 the same cycle, no rsp_valid, then a clean new write completes correctly.
REQ-042 SHALL cover CLK_DIV=2: write 0x0FF data 0x01 -> 4-cycle sclk period, frame length 104 cycles.
